// File: rtl/state_ctrl_pkg.sv
// Shared state encodings and the pass ordering used by state_ctrl and state_machine.
// Codes 5-7 are illegal and always steer the sequencer back to IDLE.
package state_ctrl_pkg;

  localparam int STATE_LEN = 3;

  typedef enum logic [STATE_LEN-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CALC  = 3'd2,
    ST_STORE = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  function automatic logic [STATE_LEN-1:0] next_state(input logic [STATE_LEN-1:0] s);
    case (s)
      ST_LOAD:  next_state = ST_CALC;
      ST_CALC:  next_state = ST_STORE;
      ST_STORE: next_state = ST_FIN;
      default:  next_state = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/state_ctrl_if.sv
// Bundle between the sequencer and its neighbours: host start/stall, the
// state_machine handshake (q/run/set/d) and the per-step datapath outputs.
interface state_ctrl_if #(
  parameter int CNT_W = 7
) ();
  import state_ctrl_pkg::*;

  logic                 start;
  logic                 stall;
  logic [STATE_LEN-1:0] q;
  logic                 run;
  logic                 set;
  logic [STATE_LEN-1:0] d;
  logic [CNT_W-1:0]     step;
  logic                 step_valid;
  logic                 done;

  modport master (
    input  start, stall, q,
    output run, set, d, step, step_valid, done
  );

  modport slave (
    output start, stall, q,
    input  run, set, d, step, step_valid, done
  );

endinterface

// File: rtl/state_ctrl_step_counter.sv
// Step counter: advances on en, wraps to zero after reaching limit, clr has priority.
module step_counter #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_reg;

  assign last = (cnt_reg == limit);
  assign cnt  = cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= last ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/state_machine.sv
// State register downstream of state_ctrl: loads d when run and set are both high.
module state_machine
  import state_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 set,
  input  logic [STATE_LEN-1:0] d,
  output logic [STATE_LEN-1:0] q
);

  logic [STATE_LEN-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= ST_IDLE;
    end else if (run && set) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/state_ctrl.sv
// Sequencer for state_machine: dwells a fixed number of steps in LOAD/CALC/STORE,
// requests each next state with a set/pending handshake, and pulses done at FIN.
module state_ctrl
  import state_ctrl_pkg::*;
#(
  parameter int LOAD_CYC  = 16,
  parameter int CALC_CYC  = 64,
  parameter int STORE_CYC = 16,
  parameter int CNT_W     = 7
) (
  input  logic clk,
  input  logic rst,
  state_ctrl_if.master bus
);

  localparam int CYC [4] = '{LOAD_CYC, CALC_CYC, STORE_CYC, 1};

  logic                 run;
  logic                 set_reg;
  logic                 pending_reg;
  logic                 step_valid_reg;
  logic                 done_reg;
  logic [STATE_LEN-1:0] d_reg;
  logic [CNT_W-1:0]     step_reg;

  logic                 working;
  logic [1:0]           lim_idx;
  logic [CNT_W-1:0]     limit_tab [4];
  logic [CNT_W-1:0]     limit;
  logic                 count_en;
  logic                 count_clr;
  logic [CNT_W-1:0]     cnt;
  logic                 last;

  assign run = !bus.stall && !rst;

  // Per-state terminal step index, indexed by q-1 for LOAD/CALC/STORE.
  for (genvar gi = 0; gi < 4; gi++) begin : g_limit
    assign limit_tab[gi] = CNT_W'(CYC[gi] - 1);
  end

  always_comb begin
    working = (bus.q == ST_LOAD) || (bus.q == ST_CALC) || (bus.q == ST_STORE);
    lim_idx = 2'(bus.q - 3'd1);
    limit   = '0;
    if (working) begin
      limit = limit_tab[lim_idx];
    end
  end

  // Counter only runs on genuine datapath steps and is parked at zero otherwise.
  assign count_en  = run && !pending_reg && working;
  assign count_clr = run && !count_en;

  step_counter #(.CNT_W(CNT_W)) u_step_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (count_en),
    .clr   (count_clr),
    .limit (limit),
    .cnt   (cnt),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      set_reg        <= 1'b0;
      d_reg          <= ST_IDLE;
      pending_reg    <= 1'b0;
      step_reg       <= '0;
      step_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
    end else if (run) begin
      done_reg       <= 1'b0;
      step_valid_reg <= 1'b0;
      step_reg       <= '0;
      if (pending_reg) begin
        // Hold the request until state_machine reflects it back on q.
        if (bus.q == d_reg) begin
          pending_reg <= 1'b0;
          set_reg     <= 1'b0;
        end
      end else begin
        case (bus.q)
          ST_IDLE: begin
            if (bus.start) begin
              set_reg     <= 1'b1;
              d_reg       <= ST_LOAD;
              pending_reg <= 1'b1;
            end
          end
          ST_LOAD, ST_CALC, ST_STORE: begin
            step_valid_reg <= 1'b1;
            step_reg       <= cnt;
            if (last) begin
              set_reg     <= 1'b1;
              d_reg       <= next_state(bus.q);
              pending_reg <= 1'b1;
            end
          end
          ST_FIN: begin
            done_reg    <= 1'b1;
            set_reg     <= 1'b1;
            d_reg       <= ST_IDLE;
            pending_reg <= 1'b1;
          end
          default: begin
            set_reg     <= 1'b1;
            d_reg       <= ST_IDLE;
            pending_reg <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.run        = run;
  assign bus.set        = set_reg;
  assign bus.d          = d_reg;
  assign bus.step       = step_reg;
  assign bus.step_valid = step_valid_reg;
  assign bus.done       = done_reg;

endmodule

// File: tb/tb_state_ctrl.sv
// Bench for state_ctrl driving a real state_machine; expected steps go into a scoreboard.
module tb_state_ctrl;
  import state_ctrl_pkg::*;

  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  state_ctrl_if #(.CNT_W(CNT_W)) bus ();

  logic       ovr_set;
  logic [2:0] ovr_d;
  logic [2:0] q;
  logic [2:0] sm_d;
  logic       sm_set;

  assign sm_set = ovr_set | bus.set;
  assign sm_d   = ovr_set ? ovr_d : bus.d;
  assign bus.q  = q;

  state_ctrl #(
    .LOAD_CYC  (2),
    .CALC_CYC  (4),
    .STORE_CYC (2),
    .CNT_W     (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  state_machine sm (
    .clk (clk),
    .rst (rst),
    .run (bus.run),
    .set (sm_set),
    .d   (sm_d),
    .q   (q)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [5:0] exp_q [$];
  logic [5:0] obs_q [$];
  logic [2:0] qtr [$];
  int         done_cnt;
  int         cyc_cnt;
  int         first_valid;
  logic [2:0] last_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    exp_q.delete();
    qtr.delete();
    done_cnt    = 0;
    cyc_cnt     = 0;
    first_valid = -1;
    last_q      = q;
  endtask

  task automatic push_pass();
    for (int i = 0; i < 2; i++) exp_q.push_back({3'(ST_LOAD), 3'(i)});
    for (int i = 0; i < 4; i++) exp_q.push_back({3'(ST_CALC), 3'(i)});
    for (int i = 0; i < 2; i++) exp_q.push_back({3'(ST_STORE), 3'(i)});
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      cyc_cnt++;
      if (bus.step_valid) begin
        obs_q.push_back({q, bus.step});
        if (first_valid < 0) first_valid = cyc_cnt;
      end
      if (bus.done) done_cnt++;
      if (q != last_q) begin
        qtr.push_back(q);
        last_q = q;
      end
    end
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({bus.set, bus.d, bus.step, bus.step_valid, bus.done, bus.run} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b exp %b",
               {bus.set, bus.d, bus.step, bus.step_valid, bus.done, bus.run}, 10'd0);
    end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.run !== 1'b1) begin
      n_fail++;
      $display("FAIL run_after_reset got %b exp 1", bus.run);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({bus.set, bus.d, bus.step_valid, bus.done, q} !== 9'd0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d got %b exp %b", i,
                 {bus.set, bus.d, bus.step_valid, bus.done, q}, 9'd0);
      end
    end
    $display("test_reset done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_full_pass();
    logic [2:0] exp_tr [5];
    exp_tr = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    start_pulse();
    n_checks++;
    if (bus.set !== 1'b1 || bus.d !== 3'(ST_LOAD)) begin
      n_fail++;
      $display("FAIL set_on_start got set=%b d=%0d exp set=1 d=1", bus.set, bus.d);
    end
    clear_obs();
    push_pass();
    observe(30);
    n_checks++;
    if (first_valid != 3) begin
      n_fail++;
      $display("FAIL start_latency got %0d exp 3", first_valid);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL pass_step_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() > 0) begin
        logic [5:0] e, o;
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL pass_step got q=%0d step=%0d exp q=%0d step=%0d", o[5:3], o[2:0], e[5:3], e[2:0]);
        end
      end
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL pass_done_cycles got %0d exp 1", done_cnt);
    end
    n_checks++;
    if (qtr.size() != 5) begin
      n_fail++;
      $display("FAIL q_trace_len got %0d exp 5", qtr.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (qtr[i] !== exp_tr[i]) begin
          n_fail++;
          $display("FAIL q_trace[%0d] got %0d exp %0d", i, qtr[i], exp_tr[i]);
        end
      end
    end
    $display("test_full_pass done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_stall_calc();
    logic found;
    found = 1'b0;
    start_pulse();
    clear_obs();
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (bus.step_valid && q == 3'(ST_CALC) && bus.step == 3'd2) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL wait_calc_step2 got timeout exp step 2 in CALC");
    end else begin
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        n_checks++;
        if ({bus.step, bus.step_valid, q, bus.run} !== {3'd2, 1'b1, 3'(ST_CALC), 1'b0}) begin
          n_fail++;
          $display("FAIL stall_hold%0d got step=%0d valid=%b q=%0d run=%b exp 2 1 2 0",
                   i, bus.step, bus.step_valid, q, bus.run);
        end
      end
      bus.stall = 1'b0;
      tick();
      n_checks++;
      if ({bus.step, bus.step_valid, bus.set, bus.d} !== {3'd3, 1'b1, 1'b1, 3'(ST_STORE)}) begin
        n_fail++;
        $display("FAIL stall_release got step=%0d valid=%b set=%b d=%0d exp 3 1 1 3",
                 bus.step, bus.step_valid, bus.set, bus.d);
      end
      tick();
      n_checks++;
      if (bus.step_valid !== 1'b0 || q !== 3'(ST_STORE)) begin
        n_fail++;
        $display("FAIL stall_to_store got valid=%b q=%0d exp 0 3", bus.step_valid, q);
      end
    end
    clear_obs();
    observe(25);
    n_checks++;
    if (done_cnt != 1 || q !== 3'(ST_IDLE)) begin
      n_fail++;
      $display("FAIL stall_calc_finish got done=%0d q=%0d exp 1 0", done_cnt, q);
    end
    $display("test_stall_calc done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_stall_pending();
    start_pulse();
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({q, bus.set, bus.d} !== {3'(ST_IDLE), 1'b1, 3'(ST_LOAD)}) begin
        n_fail++;
        $display("FAIL pend_stall%0d got q=%0d set=%b d=%0d exp 0 1 1", i, q, bus.set, bus.d);
      end
    end
    bus.stall = 1'b0;
    tick();
    n_checks++;
    if (q !== 3'(ST_LOAD) || bus.set !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_q_update got q=%0d set=%b exp 1 1", q, bus.set);
    end
    tick();
    n_checks++;
    if (bus.set !== 1'b0 || bus.step_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_set_fall got set=%b valid=%b exp 0 0", bus.set, bus.step_valid);
    end
    tick();
    n_checks++;
    if (bus.step_valid !== 1'b1 || bus.step !== 3'd0) begin
      n_fail++;
      $display("FAIL pend_first_step got valid=%b step=%0d exp 1 0", bus.step_valid, bus.step);
    end
    clear_obs();
    observe(25);
    n_checks++;
    if (done_cnt != 1 || q !== 3'(ST_IDLE) || obs_q.size() != 7) begin
      n_fail++;
      $display("FAIL pend_finish got done=%0d q=%0d steps=%0d exp 1 0 7", done_cnt, q, obs_q.size());
    end
    $display("test_stall_pending done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_start_busy();
    int guard;
    start_pulse();
    clear_obs();
    push_pass();
    guard = 0;
    while (q !== 3'(ST_CALC) && guard < 20) begin
      observe(1);
      guard++;
    end
    n_checks++;
    if (q !== 3'(ST_CALC)) begin
      n_fail++;
      $display("FAIL busy_reach_calc got q=%0d exp 2", q);
    end
    bus.start = 1'b1;
    observe(2);
    bus.start = 1'b0;
    observe(30);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL busy_step_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() > 0) begin
        logic [5:0] e, o;
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL busy_step got q=%0d step=%0d exp q=%0d step=%0d", o[5:3], o[2:0], e[5:3], e[2:0]);
        end
      end
    end
    n_checks++;
    if (done_cnt != 1 || q !== 3'(ST_IDLE)) begin
      n_fail++;
      $display("FAIL busy_done got done=%0d q=%0d exp 1 0", done_cnt, q);
    end
    $display("test_start_busy done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_illegal();
    ovr_d   = 3'd6;
    ovr_set = 1'b1;
    tick();
    ovr_set = 1'b0;
    n_checks++;
    if (q !== 3'd6) begin
      n_fail++;
      $display("FAIL illegal_forced got q=%0d exp 6", q);
    end
    tick();
    n_checks++;
    if ({bus.set, bus.d, bus.done, bus.step_valid} !== {1'b1, 3'(ST_IDLE), 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL illegal_request got set=%b d=%0d done=%b valid=%b exp 1 0 0 0",
               bus.set, bus.d, bus.done, bus.step_valid);
    end
    tick();
    n_checks++;
    if (q !== 3'(ST_IDLE) || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_return got q=%0d done=%b exp 0 0", q, bus.done);
    end
    tick();
    n_checks++;
    if (bus.set !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_settle got set=%b done=%b exp 0 0", bus.set, bus.done);
    end
    $display("test_illegal done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_rst_mid();
    int guard;
    start_pulse();
    guard = 0;
    while (!(q === 3'(ST_CALC) && bus.step_valid) && guard < 20) begin
      tick();
      guard++;
    end
    n_checks++;
    if (q !== 3'(ST_CALC)) begin
      n_fail++;
      $display("FAIL rst_reach_calc got q=%0d exp 2", q);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({bus.set, bus.d, bus.step, bus.step_valid, bus.done, bus.run, q} !== 13'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs got %b exp %b",
               {bus.set, bus.d, bus.step, bus.step_valid, bus.done, bus.run, q}, 13'd0);
    end
    rst = 1'b0;
    clear_obs();
    observe(8);
    n_checks++;
    if (obs_q.size() != 0 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL rst_idle got steps=%0d done=%0d exp 0 0", obs_q.size(), done_cnt);
    end
    start_pulse();
    clear_obs();
    push_pass();
    observe(30);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rst_repass_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() > 0) begin
        logic [5:0] e, o;
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL rst_repass_step got q=%0d step=%0d exp q=%0d step=%0d", o[5:3], o[2:0], e[5:3], e[2:0]);
        end
      end
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL rst_repass_done got %0d exp 1", done_cnt);
    end
    $display("test_rst_mid done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stall = 1'b0;
    ovr_set   = 1'b0;
    ovr_d     = 3'd0;
    test_reset();
    test_full_pass();
    test_stall_calc();
    test_stall_pending();
    test_start_busy();
    test_illegal();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
